// File: rtl/stg3_modred_pkg.sv
// ---------------------------------------------------------------------------
// stg3_modred_pkg
// Shared definitions for the stage-3 modular-reduction block:
//   MAX_STAGE   - upper bound on the number of conditional-subtract stages
//   lane_beat_t - one output lane's write beat {we, addr, data} at the
//                 default 12-bit address / 64-bit data widths
//   src_lane()  - which input lane feeds output lane k
// ---------------------------------------------------------------------------
package stg3_modred_pkg;

    localparam int MAX_STAGE   = 4;
    localparam int BEAT_ADDR_W = 12;
    localparam int BEAT_DATA_W = 64;

    typedef struct packed {
        logic                   we;
        logic [BEAT_ADDR_W-1:0] addr;
        logic [BEAT_DATA_W-1:0] data;
    } lane_beat_t;

    // Output lanes cycle through the input lanes: 0,1,..,n_sub-1,0,1,..
    function automatic int src_lane(input int k, input int n_sub);
        return k % n_sub;
    endfunction

endpackage

// File: rtl/stg3_modred_if.sv
// ---------------------------------------------------------------------------
// stg3_modred_if
// Valid/ready write bus carrying LANES parallel {we, addr, data} lanes.
//   valid - beat valid (master -> slave)
//   ready - slave can take the beat (slave -> master)
//   we    - per-lane write enable
//   addr  - per-lane write address
//   data  - per-lane data word
// ---------------------------------------------------------------------------
interface stg3_modred_if #(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
);
    logic                                 valid;
    logic                                 ready;
    logic [LANES-1:0]                     we;
    logic [LANES-1:0][ADDR_WIDTH-1:0]     addr;
    logic [LANES-1:0][DATA_WIDTH-1:0]     data;

    modport master (output valid, we, addr, data, input  ready);
    modport slave  (input  valid, we, addr, data, output ready);
endinterface

// File: rtl/stg3_modred_stage.sv
// ---------------------------------------------------------------------------
// stg3_modred_stage
// One register stage for all N_POLY lanes. Lanes enabled in SUB_MASK
// subtract (Q_LIST[k] << SHIFT) when the value is not below it; other
// lanes pass through. Everything holds while i_adv is low.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   i_adv             - pipe advance enable
//   i_valid/we/addr/data - beat entering this stage
//   o_valid/we/addr/data - registered beat leaving this stage
// ---------------------------------------------------------------------------
module stg3_modred_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int N_POLY     = 6,
    parameter int Q_WIDTH    = 35,
    parameter int SHIFT      = 0,
    parameter logic [N_POLY-1:0][Q_WIDTH-1:0] Q_LIST   = '0,
    parameter logic [N_POLY-1:0]              SUB_MASK = '0
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_adv,
    input  logic                                 i_valid,
    input  logic [N_POLY-1:0]                    i_we,
    input  logic [N_POLY-1:0][ADDR_WIDTH-1:0]    i_addr,
    input  logic [N_POLY-1:0][DATA_WIDTH-1:0]    i_data,
    output logic                                 o_valid,
    output logic [N_POLY-1:0]                    o_we,
    output logic [N_POLY-1:0][ADDR_WIDTH-1:0]    o_addr,
    output logic [N_POLY-1:0][DATA_WIDTH-1:0]    o_data
);

    function automatic logic [DATA_WIDTH-1:0] cond_sub(
        input logic [DATA_WIDTH-1:0] v,
        input logic [DATA_WIDTH-1:0] t
    );
        return (v >= t) ? (v - t) : v;
    endfunction

    logic [N_POLY-1:0][DATA_WIDTH-1:0] w_data_nxt;

    always_comb begin
        w_data_nxt = i_data;
        for (int k = 0; k < N_POLY; k++) begin
            if (SUB_MASK[k]) begin
                w_data_nxt[k] = cond_sub(i_data[k], DATA_WIDTH'(Q_LIST[k]) << SHIFT);
            end
        end
    end

    // ---- stage register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_we    <= '0;
            o_addr  <= '0;
            o_data  <= '0;
        end else if (i_adv) begin
            o_valid <= i_valid;
            o_we    <= i_we;
            o_addr  <= i_addr;
            o_data  <= w_data_nxt;
        end
    end

endmodule

// File: rtl/stg3_modred.sv
// ---------------------------------------------------------------------------
// stg3_modred
// Fans N_POLY_SUB input lanes out to N_POLY output lanes (lane k is fed by
// input lane k % N_POLY_SUB) and reduces the lanes selected in SUB_MASK
// modulo Q_LIST[k] through N_STAGE pipelined conditional subtractions.
// Inputs below 2^N_STAGE * Q come out in [0, Q). Fully registered,
// latency N_STAGE, one beat per cycle with valid/ready flow control.
// Optional build macro STG3_MODRED_RANGE_CHK_EN adds o_range_err.
// Ports:
//   clk          - clock
//   rst          - asynchronous active-high reset
//   i_up         - input bus (slave): valid/we/addr/data in, ready out
//   o_dn         - output bus (master): valid/we/addr/data out, ready in
//   o_range_err  - (macro only) sticky per-lane "left with data >= Q" flag
// ---------------------------------------------------------------------------
module stg3_modred
    import stg3_modred_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int N_POLY_SUB = 2,
    parameter int N_POLY     = 6,
    parameter int Q_WIDTH    = 35,
    parameter int N_STAGE    = 1,
    parameter logic [N_POLY-1:0][Q_WIDTH-1:0] Q_LIST =
        {35'h0, 35'h0, 35'h0, 35'h4_0008_0001, 35'h4_0800_0001, 35'h0},
    parameter logic [N_POLY-1:0] SUB_MASK = 6'b000110
)(
    input  logic                clk,
    input  logic                rst,
    stg3_modred_if.slave        i_up,
    stg3_modred_if.master       o_dn
`ifdef STG3_MODRED_RANGE_CHK_EN
    ,
    output logic [N_POLY-1:0]   o_range_err
`endif
);

    if (N_POLY % N_POLY_SUB != 0) begin : g_err_lanes
        $error("stg3_modred: N_POLY must be a multiple of N_POLY_SUB");
    end
    if (N_STAGE < 1 || N_STAGE > MAX_STAGE) begin : g_err_stages
        $error("stg3_modred: N_STAGE must be in 1..MAX_STAGE");
    end
    if (Q_WIDTH + N_STAGE - 1 > DATA_WIDTH) begin : g_err_width
        $error("stg3_modred: Q_WIDTH+N_STAGE-1 exceeds DATA_WIDTH");
    end

    function automatic logic [N_POLY-1:0] fan_we(input logic [N_POLY_SUB-1:0] we);
        for (int k = 0; k < N_POLY; k++) fan_we[k] = we[src_lane(k, N_POLY_SUB)];
    endfunction

    function automatic logic [N_POLY-1:0][ADDR_WIDTH-1:0] fan_addr(
        input logic [N_POLY_SUB-1:0][ADDR_WIDTH-1:0] addr
    );
        for (int k = 0; k < N_POLY; k++) fan_addr[k] = addr[src_lane(k, N_POLY_SUB)];
    endfunction

    function automatic logic [N_POLY-1:0][DATA_WIDTH-1:0] fan_data(
        input logic [N_POLY_SUB-1:0][DATA_WIDTH-1:0] data
    );
        for (int k = 0; k < N_POLY; k++) fan_data[k] = data[src_lane(k, N_POLY_SUB)];
    endfunction

    // Index 0 is the fanned-out input; index s+1 is the output of stage s.
    logic                              w_vld  [N_STAGE+1];
    logic [N_POLY-1:0]                 w_we   [N_STAGE+1];
    logic [N_POLY-1:0][ADDR_WIDTH-1:0] w_addr [N_STAGE+1];
    logic [N_POLY-1:0][DATA_WIDTH-1:0] w_data [N_STAGE+1];
    logic                              w_adv;

    // The whole pipe moves together; it only stalls when the last stage
    // holds a beat the consumer is refusing.
    assign w_adv      = o_dn.ready | ~o_dn.valid;
    assign i_up.ready = w_adv;

    assign w_vld[0]  = i_up.valid;
    assign w_we[0]   = fan_we(i_up.we);
    assign w_addr[0] = fan_addr(i_up.addr);
    assign w_data[0] = fan_data(i_up.data);

    // Largest multiple of Q is taken off first so each later stage only
    // has to remove a smaller one.
    for (genvar s = 0; s < N_STAGE; s++) begin : g_stage
        stg3_modred_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .N_POLY     (N_POLY),
            .Q_WIDTH    (Q_WIDTH),
            .SHIFT      (N_STAGE - 1 - s),
            .Q_LIST     (Q_LIST),
            .SUB_MASK   (SUB_MASK)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_adv   (w_adv),
            .i_valid (w_vld[s]),
            .i_we    (w_we[s]),
            .i_addr  (w_addr[s]),
            .i_data  (w_data[s]),
            .o_valid (w_vld[s+1]),
            .o_we    (w_we[s+1]),
            .o_addr  (w_addr[s+1]),
            .o_data  (w_data[s+1])
        );
    end

    assign o_dn.valid = w_vld[N_STAGE];
    assign o_dn.we    = w_we[N_STAGE];
    assign o_dn.addr  = w_addr[N_STAGE];
    assign o_dn.data  = w_data[N_STAGE];

`ifdef STG3_MODRED_RANGE_CHK_EN
    logic [N_POLY-1:0] r_range_err;

    // ---- sticky range flags, sampled as beats leave ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range_err <= '0;
        end else if (o_dn.valid && o_dn.ready) begin
            for (int k = 0; k < N_POLY; k++) begin
                if (SUB_MASK[k] && (o_dn.data[k] >= DATA_WIDTH'(Q_LIST[k]))) begin
                    r_range_err[k] <= 1'b1;
                end
            end
        end
    end

    assign o_range_err = r_range_err;
`endif

endmodule

// File: tb/tb_stg3_modred.sv
module tb_stg3_modred;
    import stg3_modred_pkg::*;

    localparam logic [63:0] Q1 = 64'h4_0800_0001;
    localparam logic [63:0] Q2 = 64'h4_0008_0001;
    localparam logic [5:0]  MASK = 6'b000110;

    typedef struct {
        logic [1:0]       we;
        logic [1:0][11:0] addr;
        logic [1:0][63:0] data;
    } in_beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stg3_modred_if #(.LANES(2)) ia_up ();
    stg3_modred_if #(.LANES(6)) ia_dn ();
    stg3_modred_if #(.LANES(2)) ib_up ();
    stg3_modred_if #(.LANES(6)) ib_dn ();

`ifdef STG3_MODRED_RANGE_CHK_EN
    logic [5:0] err_a, err_b;
`endif

    stg3_modred #(.N_STAGE(1)) u_dut_a (
        .clk  (clk),
        .rst  (rst),
        .i_up (ia_up),
        .o_dn (ia_dn)
`ifdef STG3_MODRED_RANGE_CHK_EN
        , .o_range_err (err_a)
`endif
    );

    stg3_modred #(.N_STAGE(2)) u_dut_b (
        .clk  (clk),
        .rst  (rst),
        .i_up (ib_up),
        .o_dn (ib_dn)
`ifdef STG3_MODRED_RANGE_CHK_EN
        , .o_range_err (err_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_a, cnt_b;
    bit acc_a;
    in_beat_t cur;
    in_beat_t qa[$];
    in_beat_t qb[$];

    function automatic logic [63:0] q_of(input int k);
        return (k == 1) ? Q1 : (k == 2) ? Q2 : 64'd0;
    endfunction

    // Subtract as many whole moduli as possible, at most 2^ns-1 of them.
    function automatic logic [63:0] red(input logic [63:0] v, input logic [63:0] q, input int ns);
        logic [63:0] m;
        if (q == 64'd0) return v;
        m = v / q;
        if (m > 64'((1 << ns) - 1)) m = 64'((1 << ns) - 1);
        return v - m * q;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input in_beat_t b, input int ns,
                             input logic [5:0] we, input logic [5:0][11:0] addr,
                             input logic [5:0][63:0] data);
        lane_beat_t e, o;
        for (int k = 0; k < 6; k++) begin
            e.we   = b.we[k % 2];
            e.addr = b.addr[k % 2];
            e.data = MASK[k] ? red(b.data[k % 2], q_of(k), ns) : b.data[k % 2];
            o.we   = we[k];
            o.addr = addr[k];
            o.data = data[k];
            chk($sformatf("%s beat lane%0d", tag, k), 128'(o), 128'(e));
        end
    endtask

    task automatic drive(input logic v, input in_beat_t b);
        cur = b;
        ia_up.valid = v; ia_up.we = b.we; ia_up.addr = b.addr; ia_up.data = b.data;
        ib_up.valid = v; ib_up.we = b.we; ib_up.addr = b.addr; ib_up.data = b.data;
    endtask

    task automatic set_rdy(input logic r);
        ia_dn.ready = r;
        ib_dn.ready = r;
    endtask

    task automatic step();
        @(negedge clk);
        acc_a = ia_up.valid && ia_up.ready;
        if (ia_dn.valid && ia_dn.ready) begin
            chk("A beat expected", 128'(qa.size() != 0), 128'(1));
            if (qa.size() != 0) begin
                check_out("A", qa.pop_front(), 1, ia_dn.we, ia_dn.addr, ia_dn.data);
                cnt_a++;
            end
        end
        if (ib_dn.valid && ib_dn.ready) begin
            chk("B beat expected", 128'(qb.size() != 0), 128'(1));
            if (qb.size() != 0) begin
                check_out("B", qb.pop_front(), 2, ib_dn.we, ib_dn.addr, ib_dn.data);
                cnt_b++;
            end
        end
        if (acc_a) qa.push_back(cur);
        if (ib_up.valid && ib_up.ready) qb.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    function automatic in_beat_t rnd_beat();
        in_beat_t b;
        b.we      = 2'($urandom);
        b.addr[0] = 12'($urandom);
        b.addr[1] = 12'($urandom);
        b.data[1] = {$urandom(), $urandom()} % (2 * Q1);
        b.data[0] = {$urandom(), $urandom()} % (2 * Q2);
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_beat_t b;
        in_beat_t sb [16];
        logic [5:0][63:0] sav;
        int idx;

        b = '{we: 2'b00, addr: '0, data: '0};
        rst = 1'b1;
        drive(1'b0, b);
        set_rdy(1'b1);
        @(posedge clk); #1;

        // Reset state
        chk("reset A o_valid", 128'(ia_dn.valid), 128'(0));
        chk("reset A o_data",  128'(ia_dn.data[1]), 128'(0));
        chk("reset B o_valid", 128'(ib_dn.valid), 128'(0));
        chk("reset B o_we",    128'(ib_dn.we), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle A o_ready", 128'(ia_up.ready), 128'(1));
        chk("idle B o_ready", 128'(ib_up.ready), 128'(1));

        // Basic reduction, N_STAGE=1 and N_STAGE=2
        b = '{we: 2'b11, addr: '{12'h011, 12'h022}, data: '{64'h4_0800_0005, 64'h4_0008_0003}};
        drive(1'b1, b);
        step();
        drive(1'b0, b);
        chk("t1 A o_valid",  128'(ia_dn.valid), 128'(1));
        chk("t1 A data1",    128'(ia_dn.data[1]), 128'(4));
        chk("t1 A data2",    128'(ia_dn.data[2]), 128'(2));
        chk("t1 A data3",    128'(ia_dn.data[3]), 128'(64'h4_0800_0005));
        chk("t1 A data0",    128'(ia_dn.data[0]), 128'(64'h4_0008_0003));
        chk("t1 A data4",    128'(ia_dn.data[4]), 128'(64'h4_0008_0003));
        chk("t1 B latency",  128'(ib_dn.valid), 128'(0));
        step();
        chk("t1 B o_valid",  128'(ib_dn.valid), 128'(1));
        chk("t1 B data1",    128'(ib_dn.data[1]), 128'(4));
        chk("t1 A drained",  128'(ia_dn.valid), 128'(0));
        step();

        // we/addr duplication
        b = '{we: 2'b10, addr: '{12'h0A5, 12'h3FF}, data: '0};
        drive(1'b1, b);
        step();
        drive(1'b0, b);
        chk("t5 o_we",   128'(ia_dn.we), 128'(6'b101010));
        chk("t5 addr5",  128'(ia_dn.addr[5]), 128'(12'h0A5));
        chk("t5 addr3",  128'(ia_dn.addr[3]), 128'(12'h0A5));
        chk("t5 addr4",  128'(ia_dn.addr[4]), 128'(12'h3FF));
        chk("t5 addr0",  128'(ia_dn.addr[0]), 128'(12'h3FF));
        step(); step();

        // N_STAGE=2: 3*Q+7 -> 7, Q-1 -> unchanged
        b = '{we: 2'b11, addr: '{12'h001, 12'h002}, data: '{64'hC_1800_000A, 64'd5}};
        drive(1'b1, b);
        step();
        chk("t2 B latency", 128'(ib_dn.valid), 128'(0));
        b.data[1] = Q1 - 64'd1;
        drive(1'b1, b);
        step();
        drive(1'b0, b);
        chk("t2 B o_valid", 128'(ib_dn.valid), 128'(1));
        chk("t2 B 3Q+7",    128'(ib_dn.data[1]), 128'(7));
        step();
        chk("t2 B Q-1",     128'(ib_dn.data[1]), 128'(Q1 - 64'd1));
        step(); step();

        // 16 back-to-back beats with a consumer stall on cycles 3..6
        for (int i = 0; i < 16; i++) sb[i] = rnd_beat();
        cnt_a = 0; cnt_b = 0; idx = 0;
        for (int c = 0; c < 200 && (idx < 16 || qa.size() != 0 || qb.size() != 0); c++) begin
            set_rdy(!(c >= 3 && c <= 6));
            drive(idx < 16, (idx < 16) ? sb[idx] : sb[15]);
            #1;
            if (c >= 3 && c <= 6) begin
                chk("stall A o_ready", 128'(ia_up.ready), 128'(0));
                chk("stall B o_ready", 128'(ib_up.ready), 128'(0));
                chk("stall A o_valid", 128'(ia_dn.valid), 128'(1));
                if (c == 3) sav = ia_dn.data;
                else chk("stall A held", 128'(ia_dn.data[1] ^ sav[1]) | 128'(ia_dn.data[2] ^ sav[2]), 128'(0));
            end
            step();
            if (acc_a) idx++;
        end
        drive(1'b0, sb[0]);
        set_rdy(1'b1);
        chk("stream A count", 128'(cnt_a), 128'(16));
        chk("stream B count", 128'(cnt_b), 128'(16));

        // Reset with two beats in flight in B
        b = rnd_beat();
        drive(1'b1, b);
        step();
        b = rnd_beat();
        drive(1'b1, b);
        step();
        drive(1'b0, b);
        rst = 1'b1;
        #1;
        chk("rst A o_valid", 128'(ia_dn.valid), 128'(0));
        chk("rst B o_valid", 128'(ib_dn.valid), 128'(0));
        chk("rst B o_data",  128'(ib_dn.data[1]), 128'(0));
`ifdef STG3_MODRED_RANGE_CHK_EN
        chk("rst A err clr", 128'(err_a), 128'(0));
`endif
        qa.delete(); qb.delete();
        #1;
        rst = 1'b0;
        b = rnd_beat();
        drive(1'b1, b);
        cnt_b = 0;
        step();
        drive(1'b0, b);
        chk("post-rst B latency", 128'(ib_dn.valid), 128'(0));
        step();
        chk("post-rst B o_valid", 128'(ib_dn.valid), 128'(1));
        step();
        chk("post-rst B alone",   128'(ib_dn.valid), 128'(0));
        chk("post-rst B count",   128'(cnt_b), 128'(1));

        // Randomised traffic with random consumer back-pressure
        for (int c = 0; c < 80; c++) begin
            drive(1'($urandom), rnd_beat());
            set_rdy(($urandom % 4) != 0);
            step();
        end
        drive(1'b0, b);
        set_rdy(1'b1);
        for (int c = 0; c < 20 && (qa.size() != 0 || qb.size() != 0); c++) step();
        chk("random A drained", 128'(qa.size()), 128'(0));
        chk("random B drained", 128'(qb.size()), 128'(0));

        // Out-of-range input on A: 2*Q+1 -> Q+1
`ifdef STG3_MODRED_RANGE_CHK_EN
        chk("err A clean", 128'(err_a), 128'(0));
        chk("err B clean", 128'(err_b), 128'(0));
`endif
        b = '{we: 2'b11, addr: '0, data: '{2 * Q1 + 64'd1, 64'd0}};
        drive(1'b1, b);
        step();
        drive(1'b0, b);
        chk("t6 A data1", 128'(ia_dn.data[1]), 128'(Q1 + 64'd1));
        step();
`ifdef STG3_MODRED_RANGE_CHK_EN
        chk("t6 A err set", 128'(err_a), 128'(6'b000010));
`endif
        step(); step(); step();
`ifdef STG3_MODRED_RANGE_CHK_EN
        chk("t6 A err sticky", 128'(err_a), 128'(6'b000010));
        chk("t6 B err clean",  128'(err_b), 128'(0));
        rst = 1'b1;
        #1;
        chk("t6 A err rst", 128'(err_a), 128'(0));
        #1;
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
